// File: rtl/multimode_counter.sv
//------------------------------------------------------------------------------
// Module   : multimode_counter
// Purpose  : WIDTH-bit counter with binary up/down and Johnson up/down modes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multimode_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             err
);

  localparam logic [1:0]       c_bin_down  = 2'b00;
  localparam logic [1:0]       c_bin_up    = 2'b01;
  localparam logic [1:0]       c_john_down = 2'b10;
  localparam logic [1:0]       c_john_up   = 2'b11;
  localparam logic [WIDTH-1:0] c_zero      = '0;
  localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_msb       = WIDTH'(1) << (WIDTH - 1);

  logic [WIDTH-1:0] r_out;
  logic             r_err;
  logic [WIDTH-1:0] w_next;
  logic             w_next_err;
  logic             w_out_legal;
  logic             w_load_legal;

  // A Johnson code has at most one boundary between adjacent bits.
  function automatic logic is_johnson(input logic [WIDTH-1:0] v);
    logic [WIDTH-2:0] d;
    d = v[WIDTH-2:0] ^ v[WIDTH-1:1];
    return (d & (d - (WIDTH-1)'(1))) == '0;
  endfunction

  assign w_out_legal  = is_johnson(r_out);
  assign w_load_legal = is_johnson(load_val);

  always_comb begin
    w_next     = r_out;
    w_next_err = 1'b0;
    if (load) begin
      if (mode[1] && !w_load_legal) begin
        w_next     = c_zero;
        w_next_err = 1'b1;
      end else begin
        w_next = load_val;
      end
    end else if (en) begin
      case (mode)
        c_bin_down: begin
          if (r_out == c_zero || r_out > limit) w_next = limit;
          else                                  w_next = r_out - c_one;
        end
        c_bin_up: begin
          if (r_out >= limit) w_next = c_zero;
          else                w_next = r_out + c_one;
        end
        c_john_down: begin
          if (!w_out_legal) begin
            w_next     = c_zero;
            w_next_err = 1'b1;
          end else begin
            w_next = {r_out[WIDTH-2:0], ~r_out[WIDTH-1]};
          end
        end
        default: begin
          if (!w_out_legal) begin
            w_next     = c_zero;
            w_next_err = 1'b1;
          end else begin
            w_next = {~r_out[0], r_out[WIDTH-1:1]};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= c_zero;
      r_err <= 1'b0;
    end else begin
      r_out <= w_next;
      r_err <= w_next_err;
    end
  end

  assign out = r_out;
  assign err = r_err;
  assign tc  = (mode == c_bin_down)  ? (r_out == c_zero) :
               (mode == c_bin_up)    ? (r_out >= limit) :
               (mode == c_john_down) ? (r_out == c_msb) :
               (mode == c_john_up)   ? (r_out == c_one) : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_multimode_counter.sv
//------------------------------------------------------------------------------
// Module   : tb_multimode_counter
// Purpose  : Vector table, corner sequences and randomized model check.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multimode_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] limit = '0;
  logic [W-1:0] out;
  logic         tc;
  logic         err;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    logic         ld;
    logic         e;
    logic [W-1:0] lv;
    logic [1:0]   md;
    logic [W-1:0] lim;
    logic [W-1:0] eo;
    logic         etc;
    logic         eerr;
  } vec_t;

  vec_t tv[$];

  multimode_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .limit(limit), .out(out), .tc(tc), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, input logic e, input int lv, input logic [1:0] md,
                     input int lim, input int eo, input logic etc, input logic eerr);
    vec_t v;
    v.ld = ld; v.e = e; v.lv = W'(lv); v.md = md; v.lim = W'(lim);
    v.eo = W'(eo); v.etc = etc; v.eerr = eerr;
    tv.push_back(v);
  endtask

  task automatic step(input logic ld, input logic e, input logic [W-1:0] lv,
                      input logic [1:0] md, input logic [W-1:0] lim);
    @(negedge clk);
    load = ld; en = e; load_val = lv; mode = md; limit = lim;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; load = 1'b0; en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: Johnson codes as positions on a ring of 2*W codes.
  function automatic logic [W-1:0] jcode(input int k);
    if (k <= W) return W'(((1 << k) - 1) << (W - k));
    return W'((1 << (2 * W - k)) - 1);
  endfunction

  function automatic int jidx(input logic [W-1:0] v);
    for (int k = 0; k < 2 * W; k++)
      if (jcode(k) == v) return k;
    return -1;
  endfunction

  function automatic logic model_tc(input logic [W-1:0] o, input logic [1:0] md,
                                    input logic [W-1:0] lim);
    case (md)
      2'b00:   return int'(o) == 0;
      2'b01:   return int'(o) >= int'(lim);
      2'b10:   return o == jcode(1);
      default: return o == jcode(2 * W - 1);
    endcase
  endfunction

  task automatic model_step(inout logic [W-1:0] o, output logic e_o,
                            input logic ld, input logic e, input logic [W-1:0] lv,
                            input logic [1:0] md, input logic [W-1:0] lim);
    int k;
    int lo;
    int li;
    e_o = 1'b0;
    lo = int'(o);
    li = int'(lim);
    if (ld) begin
      if (md[1] && jidx(lv) < 0) begin
        o = '0; e_o = 1'b1;
      end else begin
        o = lv;
      end
    end else if (e) begin
      case (md)
        2'b00: o = (lo == 0 || lo > li) ? lim : W'(lo - 1);
        2'b01: o = (lo >= li) ? '0 : W'((lo + 1) % (1 << W));
        default: begin
          k = jidx(o);
          if (k < 0) begin
            o = '0; e_o = 1'b1;
          end else begin
            o = jcode((k + (md[0] ? 1 : 2 * W - 1)) % (2 * W));
          end
        end
      endcase
    end
  endtask

  initial begin
    logic [W-1:0] m_out;
    logic         m_err;
    logic         r_ld, r_e;
    logic [W-1:0] r_lv, r_lim;
    logic [1:0]   r_md;

    // binary down, limit 5
    for (int i = 0; i < 8; i++)
      add(0, 1, 0, 2'b00, 5, (i == 7) ? 4 : (5 - (i % 6)), (i == 5), 0);
    // binary up, limit 9, load above limit
    add(1, 0, 12, 2'b01, 9, 12, 1, 0);
    add(0, 1, 0, 2'b01, 9, 0, 0, 0);
    add(0, 1, 0, 2'b01, 9, 1, 0, 0);
    add(0, 1, 0, 2'b01, 9, 2, 0, 0);
    add(1, 0, 8, 2'b01, 9, 8, 0, 0);
    add(0, 1, 0, 2'b01, 9, 9, 1, 0);
    add(0, 1, 0, 2'b01, 9, 0, 0, 0);
    // Johnson up then reverse mid-walk
    add(1, 0, 0, 2'b11, 0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 0, 8, 0, 0);
    add(0, 1, 0, 2'b11, 0, 12, 0, 0);
    add(0, 1, 0, 2'b11, 0, 14, 0, 0);
    add(0, 1, 0, 2'b11, 0, 15, 0, 0);
    add(0, 1, 0, 2'b11, 0, 7, 0, 0);
    add(0, 1, 0, 2'b10, 0, 15, 0, 0);
    add(0, 1, 0, 2'b10, 0, 14, 0, 0);
    add(0, 1, 0, 2'b10, 0, 12, 0, 0);
    add(0, 1, 0, 2'b10, 0, 8, 1, 0);
    add(0, 1, 0, 2'b10, 0, 0, 0, 0);
    // full Johnson up ring
    add(1, 0, 0, 2'b11, 3, 0, 0, 0);
    add(0, 1, 0, 2'b11, 3, 8, 0, 0);
    add(0, 1, 0, 2'b11, 3, 12, 0, 0);
    add(0, 1, 0, 2'b11, 3, 14, 0, 0);
    add(0, 1, 0, 2'b11, 3, 15, 0, 0);
    add(0, 1, 0, 2'b11, 3, 7, 0, 0);
    add(0, 1, 0, 2'b11, 3, 3, 0, 0);
    add(0, 1, 0, 2'b11, 3, 1, 1, 0);
    add(0, 1, 0, 2'b11, 3, 0, 0, 0);
    add(0, 1, 0, 2'b11, 3, 8, 0, 0);
    // illegal Johnson recovery
    add(1, 0, 5, 2'b01, 9, 5, 0, 0);
    add(0, 1, 0, 2'b11, 9, 0, 0, 1);
    add(0, 1, 0, 2'b11, 9, 8, 0, 0);
    add(1, 0, 10, 2'b10, 9, 0, 0, 1);
    // load beats enable, then hold
    add(1, 1, 3, 2'b00, 5, 3, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 9, 2'b00, 5, 3, 0, 0);
    // limit zero
    add(0, 1, 0, 2'b00, 0, 0, 1, 0);
    add(0, 1, 0, 2'b00, 0, 0, 1, 0);
    add(0, 1, 0, 2'b01, 0, 0, 1, 0);
    // down from above limit, up wrap at full scale
    add(1, 0, 12, 2'b00, 9, 12, 0, 0);
    add(0, 1, 0, 2'b00, 9, 9, 0, 0);
    add(1, 0, 15, 2'b01, 15, 15, 1, 0);
    add(0, 1, 0, 2'b01, 15, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(out), 0);
    check("reset_err", 32'(err), 0);
    check("reset_tc", 32'(tc), 1);
    @(negedge clk);
    reset = 1'b0;

    foreach (tv[i]) begin
      step(tv[i].ld, tv[i].e, tv[i].lv, tv[i].md, tv[i].lim);
      check($sformatf("vec%0d_out", i), 32'(out), 32'(tv[i].eo));
      check($sformatf("vec%0d_tc", i), 32'(tc), 32'(tv[i].etc));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(tv[i].eerr));
    end

    // asynchronous reset between edges
    step(1, 0, 7, 2'b01, 15);
    check("pre_async_out", 32'(out), 7);
    #2 reset = 1'b1;
    #1;
    check("async_out", 32'(out), 0);
    check("async_err", 32'(err), 0);
    @(negedge clk);
    reset = 1'b0; en = 1'b1; load = 1'b0;
    @(posedge clk);
    #1;
    check("resume_out", 32'(out), 1);

    // reset clears a pending error pulse
    step(1, 0, 10, 2'b10, 15);
    check("err_before_rst", 32'(err), 1);
    #2 reset = 1'b1;
    #1;
    check("err_async_clr", 32'(err), 0);

    // randomized comparison against the reference model
    do_reset();
    m_out = '0;
    m_err = 1'b0;
    for (int i = 0; i < 500; i++) begin
      r_ld  = ($urandom_range(0, 7) == 0);
      r_e   = ($urandom_range(0, 3) != 0);
      r_lv  = W'($urandom);
      r_md  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : mode;
      r_lim = ($urandom_range(0, 15) == 0) ? W'($urandom) : limit;
      model_step(m_out, m_err, r_ld, r_e, r_lv, r_md, r_lim);
      step(r_ld, r_e, r_lv, r_md, r_lim);
      check($sformatf("rnd%0d_out", i), 32'(out), 32'(m_out));
      check($sformatf("rnd%0d_err", i), 32'(err), 32'(m_err));
      check($sformatf("rnd%0d_tc", i), 32'(tc), 32'(model_tc(m_out, r_md, r_lim)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

`default_nettype wire
